// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multi-cycle multiply/divide unit:
//   - mdu_op_e    : operation codes driven on mdu_unit.op
//   - mdu_state_e : sequencer states
//   - mdu_acc_e   : how the shadow result combines with HI/LO at commit
//   - cnt_width() : width of the latency down-counter
// -----------------------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } mdu_acc_e;

  // Counter must hold the larger of the two latencies.
  function automatic int unsigned cnt_width(input int unsigned mul_cycles,
                                            input int unsigned div_cycles);
    int unsigned m;
    m = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
    return int'($clog2(m + 1));
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// -----------------------------------------------------------------------------
// mdu_div_core
// Combinational signed/unsigned divider.
//   a, b       : dividend, divisor
//   is_signed  : 1 = two's-complement divide, 0 = unsigned divide
//   quotient   : truncated toward zero
//   remainder  : carries the sign of the dividend
// Divide by zero yields quotient = all ones, remainder = a.
// Signed MIN / -1 yields quotient = MIN, remainder = 0.
// -----------------------------------------------------------------------------
module mdu_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;

  always_comb begin
    neg_a     = is_signed & a[WIDTH-1];
    neg_b     = is_signed & b[WIDTH-1];
    mag_a     = neg_a ? -a : a;
    mag_b     = neg_b ? -b : b;
    uq        = '0;
    ur        = '0;
    quotient  = '0;
    remainder = '0;
    if (b == '0) begin
      quotient  = '1;
      remainder = a;
    end else if (is_signed && (a == MIN_VAL) && (b == '1)) begin
      quotient  = MIN_VAL;
      remainder = '0;
    end else begin
      // Divide magnitudes, then restore signs.
      uq        = mag_a / mag_b;
      ur        = mag_a % mag_b;
      quotient  = (neg_a ^ neg_b) ? -uq : uq;
      remainder = neg_a ? -ur : ur;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at issue and parked in a shadow register; a down
// counter models the fixed latency and HI/LO are written when it expires.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    issue pulse for op
//   op       operation code (mdu_pkg::mdu_op_e)
//   a, b     operands rs, rt
//   flush    cancel in-flight op / suppress issue this cycle
//   busy     long operation in flight
//   done     one-cycle pulse after HI/LO commit
//   hi, lo   HI/LO registers
//
// Build option: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU; without it
// those codes are ignored like any undefined op.
// -----------------------------------------------------------------------------
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned   CW       = cnt_width(MUL_CYCLES, DIV_CYCLES);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mdu_op_e            op_e;
  mdu_state_e         state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [WIDTH-1:0]   hi_n, lo_n, hi_n_nxt, lo_n_nxt;
  mdu_acc_e           acc, acc_nxt;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt;
  logic               done_nxt;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   quo, rem;
  logic               long_op, mt_hi, mt_lo;
  logic [CW-1:0]      long_load;
  logic [2*WIDTH-1:0] long_res;
  mdu_acc_e           long_acc;
  logic [2*WIDTH-1:0] commit_val;

  assign op_e   = mdu_op_e'(op);
  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign busy   = (state == ST_RUN);

  mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_div (
    .a         (a),
    .b         (b),
    .is_signed (op_e == OP_DIV),
    .quotient  (quo),
    .remainder (rem)
  );

  // Operation decode: what a start would launch this cycle.
  always_comb begin
    long_op   = 1'b0;
    long_load = '0;
    long_res  = '0;
    long_acc  = ACC_NONE;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    case (op_e)
      OP_MULT:  begin long_op = 1'b1; long_load = MUL_LOAD; long_res = prod_s; end
      OP_MULTU: begin long_op = 1'b1; long_load = MUL_LOAD; long_res = prod_u; end
      OP_DIV,
      OP_DIVU:  begin long_op = 1'b1; long_load = DIV_LOAD; long_res = {rem, quo}; end
      OP_MTHI:  mt_hi = 1'b1;
      OP_MTLO:  mt_lo = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin long_op = 1'b1; long_load = MUL_LOAD; long_res = prod_s; long_acc = ACC_ADD; end
      OP_MADDU: begin long_op = 1'b1; long_load = MUL_LOAD; long_res = prod_u; long_acc = ACC_ADD; end
      OP_MSUB:  begin long_op = 1'b1; long_load = MUL_LOAD; long_res = prod_s; long_acc = ACC_SUB; end
      OP_MSUBU: begin long_op = 1'b1; long_load = MUL_LOAD; long_res = prod_u; long_acc = ACC_SUB; end
`endif
      default: ;
    endcase
  end

  // Accumulating ops fold in HI/LO as they stand at commit, not at issue.
  always_comb begin
    case (acc)
      ACC_ADD: commit_val = {hi, lo} + {hi_n, lo_n};
      ACC_SUB: commit_val = {hi, lo} - {hi_n, lo_n};
      default: commit_val = {hi_n, lo_n};
    endcase
  end

  // Next-state logic. Starts are only looked at in IDLE, so a start while
  // busy is dropped without side effects.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_n_nxt  = hi_n;
    lo_n_nxt  = lo_n;
    acc_nxt   = acc;
    hi_nxt    = hi;
    lo_nxt    = lo;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !flush) begin
          if (long_op) begin
            state_nxt            = ST_RUN;
            cnt_nxt              = long_load;
            {hi_n_nxt, lo_n_nxt} = long_res;
            acc_nxt              = long_acc;
          end else if (mt_hi) begin
            hi_nxt = a;
          end else if (mt_lo) begin
            lo_nxt = a;
          end
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_ONE) begin
          state_nxt        = ST_IDLE;
          cnt_nxt          = '0;
          {hi_nxt, lo_nxt} = commit_val;
          done_nxt         = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi_n  <= '0;
      lo_n  <= '0;
      acc   <= ACC_NONE;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi_n  <= hi_n_nxt;
      lo_n  <= lo_n_nxt;
      acc   <= acc_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// -----------------------------------------------------------------------------
// tb_mdu_unit
// Self-checking bench for mdu_unit. Expected HI/LO come from an arithmetic
// reference model (64-bit integer math); latency and handshake from the
// configured cycle counts. Honours MDU_MADD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mdu_unit;

  localparam int unsigned W    = 32;
  localparam int unsigned MULC = 5;
  localparam int unsigned DIVC = 10;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b1;
  logic          start   = 1'b0;
  logic          flush   = 1'b0;
  logic [3:0]    op      = '0;
  logic [W-1:0]  a       = '0;
  logic [W-1:0]  b       = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int            total = 0;
  int            bad   = 0;
  logic [63:0]   m_hl  = '0;

  always #5 clk = ~clk;

  mdu_unit #(
    .WIDTH      (W),
    .MUL_CYCLES (MULC),
    .DIV_CYCLES (DIVC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_long(input int opc);
    if (opc >= 1 && opc <= 4) return 1'b1;
`ifdef MDU_MADD_EN
    if (opc >= 7 && opc <= 10) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int lat(input int opc);
    return (opc == 3 || opc == 4) ? int'(DIVC) : int'(MULC);
  endfunction

  // Reference: {hi,lo} after op opc with operands x,y starting from hl.
  function automatic logic [63:0] model(input int opc, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] hl);
    longint          sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    logic [63:0]     ps, pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    ps = sx * sy;
    pu = ux * uy;
    case (opc)
      1: return ps;
      2: return pu;
      3: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      4: begin
        if (y == 32'h0) return {x, 32'hFFFFFFFF};
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
      5: return {x, hl[31:0]};
      6: return {hl[63:32], x};
`ifdef MDU_MADD_EN
      7:  return hl + ps;
      8:  return hl + pu;
      9:  return hl - ps;
      10: return hl - pu;
`endif
      default: return hl;
    endcase
  endfunction

  // Called just after a negedge; returns just after a negedge.
  task automatic do_op(input int opc, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] exp;
    int          n;
    exp   = model(opc, x, y, m_hl);
    start = 1'b1; op = 4'(opc); a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = '0;
    if (is_long(opc)) begin
      n = 0;
      while (busy === 1'b1 && n < 100) begin
        n++;
        @(negedge clk);
      end
      check($sformatf("latency_op%0d", opc), 64'(n), 64'(lat(opc)));
      check($sformatf("done_op%0d", opc), {63'h0, done}, 64'h1);
    end else begin
      check($sformatf("nobusy_op%0d", opc), {63'h0, busy}, 64'h0);
      check($sformatf("nodone_op%0d", opc), {63'h0, done}, 64'h0);
    end
    check($sformatf("hi_op%0d", opc), {32'h0, hi}, {32'h0, exp[63:32]});
    check($sformatf("lo_op%0d", opc), {32'h0, lo}, {32'h0, exp[31:0]});
    m_hl = exp;
    if (is_long(opc)) begin
      @(negedge clk);
      check($sformatf("done_low_op%0d", opc), {63'h0, done}, 64'h0);
    end
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_busy"}, {63'h0, busy}, 64'h0);
    check({tag, "_done"}, {63'h0, done}, 64'h0);
    check({tag, "_hilo"}, {hi, lo}, m_hl);
  endtask

  initial begin
    logic [63:0] exp;
    int          n;
    logic [31:0] x, y;
    int          opc;

    // Reset state
    #1 reset_n = 1'b0;
    #11;
    check("rst_hi",   {32'h0, hi}, 64'h0);
    check("rst_lo",   {32'h0, lo}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases
    do_op(1, 32'hFFFFFFFE, 32'h3);
    check("mult_hi_const", {32'h0, hi}, 64'hFFFFFFFF);
    check("mult_lo_const", {32'h0, lo}, 64'hFFFFFFFA);
    do_op(3, 32'hFFFFFFF9, 32'h2);
    check("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(4, 32'h7, 32'h0);
    check("divu0_const", {hi, lo}, 64'h00000007_FFFFFFFF);
    do_op(3, 32'h80000000, 32'hFFFFFFFF);
    check("divmin_const", {hi, lo}, 64'h00000000_80000000);
    do_op(3, 32'h12345, 32'h0);

    // MTHI then back-to-back MULTU
    do_op(5, 32'h12345678, 32'h0);
    check("mthi_const", {32'h0, hi}, 64'h12345678);
    do_op(2, 32'h10000, 32'h10000);
    check("multu_const", {hi, lo}, 64'h00000001_00000000);
    do_op(6, 32'hCAFEF00D, 32'h0);

    // Flush in busy cycle 4 of a DIV
    start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = '0;
    repeat (3) @(negedge clk);
    check("flush_pre_busy", {63'h0, busy}, 64'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_hold("flush_div");
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n++;
    end
    check("flush_quiet", 64'(n), 64'h0);

    // Starts while busy are ignored (MTHI and DIV attempted mid-MULT)
    x = 32'h00012345; y = 32'hFFFF0000;
    exp = model(1, x, y, m_hl);
    start = 1'b1; op = 4'd1; a = x; b = y;
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      start = (n == 2 || n == 3);
      op    = (n == 2) ? 4'd5 : 4'd4;
      a     = 32'hDEADBEEF;
      b     = '0;
      @(negedge clk);
    end
    start = 1'b0; op = '0;
    check("busy_start_latency", 64'(n), 64'(MULC));
    check("busy_start_done", {63'h0, done}, 64'h1);
    check("busy_start_hilo", {hi, lo}, exp);
    m_hl = exp;
    @(negedge clk);

    // Flush in the same cycle as start (long op and MTHI)
    start = 1'b1; op = 4'd1; a = 32'h5; b = 32'h7; flush = 1'b1;
    @(negedge clk);
    op = 4'd5;
    @(negedge clk);
    start = 1'b0; op = '0; flush = 1'b0;
    check_hold("flush_start");

    // Flush coincident with final count edge
    start = 1'b1; op = 4'd2; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0; op = '0;
    repeat (MULC - 1) @(negedge clk);
    check("flush_last_busy", {63'h0, busy}, 64'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_hold("flush_last");

    // Undefined op codes
    do_op(0, 32'h11111111, 32'h2);
    do_op(11, 32'h22222222, 32'h3);
    do_op(15, 32'h33333333, 32'h4);

    // MADDU from hi=0, lo=all ones
    do_op(5, 32'h0, 32'h0);
    do_op(6, 32'hFFFFFFFF, 32'h0);
    do_op(8, 32'h1, 32'h1);
`ifdef MDU_MADD_EN
    check("maddu_const", {hi, lo}, 64'h00000001_00000000);
    do_op(9, 32'h3, 32'hFFFFFFFF);
`else
    check("maddu_off_const", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif

    // Reset mid-MULT
    do_op(5, 32'hA5A5A5A5, 32'h0);
    start = 1'b1; op = 4'd1; a = 32'h7; b = 32'h9;
    @(negedge clk);
    start = 1'b0; op = '0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    m_hl = '0;
    check_hold("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n++;
    end
    check("rst_mid_quiet", 64'(n), 64'h0);
    check("rst_mid_hilo", {hi, lo}, 64'h0);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      opc = int'($urandom_range(0, 15));
      x   = $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'h0;
        1:       y = 32'hFFFFFFFF;
        2:       y = $urandom_range(1, 9);
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      do_op(opc, x, y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
